vga_timing_controller: RTL

Register-mapped 640x480@60 Hz VGA timing and pixel source. It is a slave on the 4-bit register bus driven by `address_decoder`, alongside the clock handler, UART and channel processor. Its ack/readback outputs are OR-combined with the other slaves. It generates hsync/vsync, the pixel coordinates and a 12-bit RGB value that is either a solid colour taken from registers or an 8-bar test pattern.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_counter.sv | 59 +++++
 rtl/vga_timing_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing block: default 640x480@60 timing,
// register offsets, CTRL bit positions and the colour-bar lookup.
package vga_pkg;
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_RED  = 2'd1;
  localparam logic [1:0] REG_GRN  = 2'd2;
  localparam logic [1:0] REG_BLU  = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PAT = 1;

  // Bars run black, blue, green, cyan, red, magenta, yellow, white.
  function automatic logic [11:0] bar_rgb(input logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction
endpackage

// File: rtl/vga_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
// Everything holds at zero while disabled.
module vga_counter #(
  parameter int PIX_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       pix_tick_o,
  output logic       frame_start_o
);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;

  assign pix_tick_o    = en_i && (div_q == DIV_LAST);
  assign frame_start_o = pix_tick_o && (h_q == '0) && (v_q == '0);
  assign h_o           = h_q;
  assign v_o           = v_q;

  always_comb begin
    div_d = div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (!en_i) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (pix_tick_o) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end
endmodule

// File: rtl/vga_timing_controller.sv
// Register-mapped VGA timing generator: bus slave for CTRL/RED/GRN/BLU,
// frame-synchronous colour shadowing and registered sync/pixel outputs.
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter logic [3:0] BASE_ADDR = 4'h8,
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [3:0]  data,
  input  logic        valid,
  output logic        ack,
  output logic [3:0]  data_out,
  output logic        data_out_valid,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] rgb
);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] BAR_W    = 10'(H_VIS / 8);

  logic [9:0] h, v;
  logic       pix_tick, frame_start;
  logic       en, pat, req, shadow_ld;
  logic       valid_q;
  // Upper CTRL bits have no function and no readback path, so only EN/PAT are kept.
  logic [1:0] ctrl_q;
  logic [2:0][3:0] stage_q, shadow_q;
  logic       ack_q, hsync_q, vsync_q, video_on_q;
  logic       hsync_d, vsync_d, video_on_d;
  logic [3:0] dout_q, dout_d;
  logic [9:0] x_q, y_q;
  logic [11:0] rgb_q, rgb_d;

  vga_counter #(
    .PIX_DIV (PIX_DIV),
    .H_TOTAL (H_VIS + H_FP + H_SYNC + H_BP),
    .V_TOTAL (V_VIS + V_FP + V_SYNC + V_BP)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .h_o           (h),
    .v_o           (v),
    .pix_tick_o    (pix_tick),
    .frame_start_o (frame_start)
  );

  assign en  = ctrl_q[CTRL_EN];
  assign pat = ctrl_q[CTRL_PAT];

  always_comb begin
    req        = valid && !valid_q && (address[3:2] == BASE_ADDR[3:2]);
    dout_d     = req ? data : 4'h0;
    shadow_ld  = !en || (pix_tick && frame_start);
    hsync_d    = !(en && (h >= HS_START) && (h < HS_STOP));
    vsync_d    = !(en && (v >= VS_START) && (v < VS_STOP));
    video_on_d = en && (h < H_VIS_C) && (v < V_VIS_C);
    rgb_d      = 12'h000;
    if (video_on_d)
      rgb_d = pat ? bar_rgb(3'(h / BAR_W)) : {shadow_q[0], shadow_q[1], shadow_q[2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      stage_q    <= '0;
      shadow_q   <= '0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rgb_q      <= '0;
    end else begin
      valid_q <= valid;
      ack_q   <= req;
      dout_q  <= dout_d;
      if (req && (address[1:0] == REG_CTRL))
        ctrl_q <= data[1:0];
      if (req && (address[1:0] != REG_CTRL))
        stage_q[address[1:0] - REG_RED] <= data;
      // Shadow load uses the pre-write staging value when both coincide.
      if (shadow_ld)
        shadow_q <= stage_q;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      x_q        <= h;
      y_q        <= v;
      rgb_q      <= rgb_d;
    end
  end

  assign ack            = ack_q;
  assign data_out_valid = ack_q;
  assign data_out       = dout_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign video_on       = video_on_q;
  assign x              = x_q;
  assign y              = y_q;
  assign rgb            = rgb_q;
endmodule
